// File: rtl/msk_key_word_loader.sv
// Masked key word loader: gathers 4 or 8 shared 32-bit words into a shared key buffer.
// Optional flush input enabled by defining MSK_KEY_LOADER_FLUSH_EN.
module msk_key_word_loader #(
  parameter int d = 2
) (
`ifdef MSK_KEY_LOADER_FLUSH_EN
  input  logic               flush_i,
`endif
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               in_mode_256_i,
  input  logic [32*d-1:0]    sh_word_in_i,
  output logic               key_valid_o,
  input  logic               key_ready_i,
  output logic               key_mode_256_o,
  output logic [256*d-1:0]   sh_key_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e             state_q;
  logic [2:0]         wcnt_q;
  logic               mode_q;
  logic               key_valid_q;
  logic [256*d-1:0]   key_q;

  logic               flush_s;
  logic               xfer_s;
  logic               last_s;

`ifdef MSK_KEY_LOADER_FLUSH_EN
  assign flush_s = flush_i;
`else
  assign flush_s = 1'b0;
`endif

  // in_ready depends on state only, so key_ready never reaches it combinationally
  assign in_ready_o     = (state_q == ST_EMPTY) || (state_q == ST_FILL);
  assign xfer_s         = in_valid_i && in_ready_o;
  assign last_s         = (wcnt_q == (mode_q ? 3'd7 : 3'd3));
  assign key_valid_o    = key_valid_q;
  assign key_mode_256_o = mode_q;
  assign sh_key_o       = key_q;

  // Control FSM: state, word counter, latched mode and key_valid
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      wcnt_q      <= 3'd0;
      mode_q      <= 1'b0;
      key_valid_q <= 1'b0;
    end else if (flush_s) begin
      state_q     <= ST_EMPTY;
      wcnt_q      <= 3'd0;
      key_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (xfer_s) begin
            mode_q  <= in_mode_256_i;
            wcnt_q  <= 3'd1;
            state_q <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (xfer_s) begin
            if (last_s) begin
              wcnt_q      <= 3'd0;
              state_q     <= ST_FULL;
              key_valid_q <= 1'b1;
            end else begin
              wcnt_q <= wcnt_q + 3'd1;
            end
          end
        end
        ST_FULL: begin
          if (key_ready_i) begin
            state_q     <= ST_EMPTY;
            key_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          wcnt_q      <= 3'd0;
          key_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Key buffer: each bit copies exactly one input share bit; no reset needed
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_s && xfer_s) begin
      key_q[32*d*wcnt_q +: 32*d] <= sh_word_in_i;
      if ((state_q == ST_EMPTY) && !in_mode_256_i) begin
        key_q[256*d-1:128*d] <= {(128*d){1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_msk_key_word_loader.sv
// Self-checking bench for msk_key_word_loader: queue-based key model plus directed tests.
module tb_msk_key_word_loader;
  localparam int D = 2;
  typedef logic [32*D-1:0]  word_t;
  typedef logic [256*D-1:0] key_t;

  logic  clk = 1'b0;
  logic  rst, in_valid, in_mode, key_ready;
  logic  flush = 1'b0;
  word_t sh_word;
  logic  in_ready, key_valid, key_mode;
  key_t  sh_key;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  msk_key_word_loader #(.d(D)) dut (
`ifdef MSK_KEY_LOADER_FLUSH_EN
    .flush_i        (flush),
`endif
    .clk_i          (clk),
    .rst_i          (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_mode_256_i  (in_mode),
    .sh_word_in_i   (sh_word),
    .key_valid_o    (key_valid),
    .key_ready_i    (key_ready),
    .key_mode_256_o (key_mode),
    .sh_key_o       (sh_key)
  );

  task automatic chk(input string nm, input key_t act, input key_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] unshare(input logic [8*D-1:0] f);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++)
      for (int s = 0; s < D; s++) b[i] = b[i] ^ f[i*D+s];
    return b;
  endfunction

  function automatic logic [8*D-1:0] share(input logic [7:0] b);
    logic [8*D-1:0] f;
    logic acc;
    for (int i = 0; i < 8; i++) begin
      acc = b[i];
      for (int s = 0; s < D-1; s++) begin
        f[i*D+s] = 1'($urandom_range(0, 1));
        acc = acc ^ f[i*D+s];
      end
      f[i*D+D-1] = acc;
    end
    return f;
  endfunction

  logic [7:0] pk [32];

  function automatic word_t shw(input int w);
    word_t r;
    for (int j = 0; j < 4; j++) r[8*D*j +: 8*D] = share(pk[4*w+j]);
    return r;
  endfunction

  // Model: a key is the concatenation of the accepted words, zero beyond them
  word_t m_words[$];
  logic  m_full = 1'b0, m_mode = 1'b0, m_init = 1'b0;
  key_t  m_key;

  always @(posedge clk) begin
    if (rst) begin
      m_words.delete(); m_full = 1'b0; m_mode = 1'b0; m_init = 1'b1;
`ifdef MSK_KEY_LOADER_FLUSH_EN
    end else if (flush) begin
      m_words.delete(); m_full = 1'b0;
`endif
    end else if (m_full) begin
      if (key_ready) m_full = 1'b0;
    end else if (in_valid) begin
      if (m_words.size() == 0) m_mode = in_mode;
      m_words.push_back(sh_word);
      if (m_words.size() == (m_mode ? 8 : 4)) begin
        m_key = '0;
        for (int i = 0; i < 32; i++)
          if (i < 4 * m_words.size())
            m_key[8*D*i +: 8*D] = m_words[i/4][8*D*(i%4) +: 8*D];
        m_full = 1'b1;
        m_words.delete();
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_init) begin
      chk("key_valid", key_t'(key_valid), key_t'(m_full));
      chk("in_ready", key_t'(in_ready), key_t'(!m_full));
      chk("key_mode_256", key_t'(key_mode), key_t'(m_mode));
      if (m_full) chk("sh_key", sh_key, m_key);
    end
  end

  task automatic put(input word_t w, input logic mode);
    @(negedge clk);
    in_valid = 1'b1; sh_word = w; in_mode = mode; key_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; key_ready = 1'b0;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    in_valid = 1'b0; key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  task automatic chk_bytes(input string nm, input int nbytes);
    for (int i = 0; i < nbytes; i++)
      chk(nm, key_t'(unshare(sh_key[8*D*i +: 8*D])), key_t'(pk[i]));
  endtask

  key_t saved;
  int   vcyc[$];
  int   idx;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; key_ready = 1'b0; sh_word = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset key_valid", key_t'(key_valid), key_t'(1'b0));
    chk("reset in_ready", key_t'(in_ready), key_t'(1'b1));

    // T1: 256-bit load; in_mode only honoured on word 0
    for (int i = 0; i < 32; i++) pk[i] = 8'($urandom);
    for (int w = 0; w < 4; w++) put(shw(w), (w == 0));
    idle(1);
    chk("t1 half key_valid", key_t'(key_valid), key_t'(1'b0));
    for (int w = 4; w < 8; w++) put(shw(w), 1'b0);
    idle(1);
    chk("t1 key_valid", key_t'(key_valid), key_t'(1'b1));
    chk("t1 mode", key_t'(key_mode), key_t'(1'b1));
    chk_bytes("t1 byte", 32);
    consume();

    // T2: 128-bit load of bytes 00..0F, upper half all-zero shares
    for (int i = 0; i < 16; i++) pk[i] = 8'(i);
    for (int w = 0; w < 4; w++) put(shw(w), 1'b0);
    idle(1);
    chk("t2 key_valid", key_t'(key_valid), key_t'(1'b1));
    chk("t2 mode", key_t'(key_mode), key_t'(1'b0));
    for (int i = 0; i < 16; i++)
      chk("t2 byte", key_t'(unshare(sh_key[8*D*i +: 8*D])), key_t'(i));
    for (int i = 16; i < 32; i++)
      chk("t2 zero field", key_t'(sh_key[8*D*i +: 8*D]), key_t'(0));

    // T3: hold FULL with pending input, then consume
    saved = sh_key;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1; key_ready = 1'b0; sh_word = word_t'({$urandom, $urandom});
      chk("t3 in_ready", key_t'(in_ready), key_t'(1'b0));
    end
    chk("t3 key stable", sh_key, saved);
    consume();
    chk("t3 key_valid drop", key_t'(key_valid), key_t'(1'b0));
    chk("t3 in_ready back", key_t'(in_ready), key_t'(1'b1));

    // T4: back-to-back 128-bit keys, always valid and always consuming
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (key_valid) vcyc.push_back(c);
      key_ready = 1'b1; in_mode = 1'b0;
      if (!m_full && idx < 12) begin
        in_valid = 1'b1; sh_word = word_t'({$urandom, $urandom}); idx++;
      end else if (idx >= 12) begin
        in_valid = 1'b0;
      end
    end
    idle(1);
    chk("t4 key count", key_t'(vcyc.size()), key_t'(3));
    for (int k = 1; k < vcyc.size(); k++)
      chk("t4 key period", key_t'(vcyc[k] - vcyc[k-1]), key_t'(5));

    // T5: reset mid-fill, then a fresh 128-bit key
    for (int i = 0; i < 16; i++) pk[i] = 8'($urandom);
    put(word_t'({$urandom, $urandom}), 1'b0);
    put(word_t'({$urandom, $urandom}), 1'b0);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int w = 0; w < 4; w++) put(shw(w), 1'b0);
    idle(1);
    chk("t5 key_valid", key_t'(key_valid), key_t'(1'b1));
    chk_bytes("t5 byte", 16);
    consume();

`ifdef MSK_KEY_LOADER_FLUSH_EN
    // T6: flush in FULL with concurrent consume, then reload
    for (int w = 0; w < 4; w++) put(shw(w), 1'b0);
    idle(1);
    @(negedge clk);
    flush = 1'b1; key_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; key_ready = 1'b0;
    chk("t6 key_valid", key_t'(key_valid), key_t'(1'b0));
    for (int i = 0; i < 16; i++) pk[i] = 8'($urandom);
    for (int w = 0; w < 4; w++) put(shw(w), 1'b0);
    idle(1);
    chk("t6 reload valid", key_t'(key_valid), key_t'(1'b1));
    chk_bytes("t6 byte", 16);
    consume();
`endif

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
